// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the round-robin ALU arbiter
//
// Purpose: state encoding, opcode values and datapath width shared by
//          alu_rr_arbiter and its eight_bit datapath.
// Ports:   none (package).

package alu_pkg;

   localparam int DATA_W = 8;

   localparam logic OPC_ADD = 1'b0;
   localparam logic OPC_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit.sv
// rtl/eight_bit.sv - combinational 8-bit add/subtract unit
//
// Purpose: {Carry,Sum} = A + B + Cin for add, A + ~B + Cin for subtract.
//          With Cin=1 the subtract yields A-B and Carry=1 means no borrow.
// Ports:   A, B    in  operands
//          Cin     in  carry-in
//          opcode  in  OPC_ADD / OPC_SUB
//          Sum     out 8-bit result, wraps modulo 256
//          Carry   out carry-out of the 9-bit result

module eight_bit
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              Cin,
   input  logic              opcode,
   output logic [DATA_W-1:0] Sum,
   output logic              Carry
);

   logic [DATA_W-1:0] b_eff;

   always_comb begin
      b_eff = (opcode == OPC_SUB) ? ~B : B;
      {Carry, Sum} = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, Cin};
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one eight_bit adder by two requesters
//
// Purpose: arbitrates two valid/ready request channels, registers the granted
//          operands, runs them through the eight_bit datapath for one cycle and
//          holds the tagged result on a valid/ready response channel.
// Ports:   clk, rst_n                     clock, async active-low reset
//          req0_* / req1_*                valid, ready, a, b, cin, op per requester
//          rsp_valid, rsp_ready           response handshake
//          rsp_id, rsp_sum, rsp_carry     response payload
//          busy                           high in EXEC or RESP
//          op_count                       completed response handshakes (wraps)

module alu_rr_arbiter
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_cin,
   input  logic              req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_cin,
   input  logic              req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_sum,
   output logic              rsp_carry,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   state_t            state_q;
   state_t            state_d;
   logic              last_grant_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              cin_q;
   logic              op_q;
   logic              id_q;

   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [DATA_W-1:0] alu_sum;
   logic              alu_carry;

   // A lone valid always wins; on a tie the requester not served last wins.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
   end

   // Gating with rst_n keeps both readies low while reset is held even though
   // the state register already sits in IDLE.
   assign req0_ready = rst_n && (state_q == IDLE) && grant0;
   assign req1_ready = rst_n && (state_q == IDLE) && grant1;
   assign accept     = req0_ready || req1_ready;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         cin_q        <= 1'b0;
         op_q         <= 1'b0;
         id_q         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_sum      <= '0;
         rsp_carry    <= 1'b0;
         op_count     <= '0;
      end else begin
         state_q <= state_d;

         // Operands are sampled only here, so the requester may change or
         // drop its inputs freely once the handshake has happened.
         if (accept) begin
            a_q          <= grant1 ? req1_a   : req0_a;
            b_q          <= grant1 ? req1_b   : req0_b;
            cin_q        <= grant1 ? req1_cin : req0_cin;
            op_q         <= grant1 ? req1_op  : req0_op;
            id_q         <= grant1;
            last_grant_q <= grant1;
         end

         if (state_q == EXEC) begin
            rsp_sum   <= alu_sum;
            rsp_carry <= alu_carry;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   eight_bit u_alu (
      .A      (a_q),
      .B      (b_q),
      .Cin    (cin_q),
      .opcode (op_q),
      .Sum    (alu_sum),
      .Carry  (alu_carry)
   );

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
//
// Purpose: drives hand-computed add/subtract vectors, round-robin fairness,
//          backpressure, counter wrap and asynchronous reset mid-operation.
// Ports:   none (top-level bench).

module tb_alu_rr_arbiter;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst_n;
   logic             req0_valid, req0_ready, req0_cin, req0_op;
   logic [7:0]       req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin, req1_op;
   logic [7:0]       req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
   logic [7:0]       rsp_sum;
   logic [CNT_W-1:0] op_count;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;

   alu_rr_arbiter #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_carry  (rsp_carry),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt_mod(input int c);
      return 32'(c % (1 << CNT_W));
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   // Starts just after a rising edge in IDLE, with rsp_ready high.
   task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic op,
                         input logic [7:0] esum, input logic ecarry);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_op = op;
      end
      @(negedge clk);
      chk("ready", id ? req1_ready : req0_ready, 1);
      @(posedge clk); #1;
      // Disturb the inputs after accept; the result must not change.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
      @(negedge clk);
      chk("exec_busy", busy, 1);
      chk("exec_no_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_sum", rsp_sum, esum);
      chk("rsp_carry", rsp_carry, ecarry);
      chk("rsp_id", rsp_id, id);
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      chk("op_count", op_count, cnt_mod(exp_cnt));
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int   got;
      logic ids [6];

      rst_n = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0; req0_cin = 1'b0; req0_op = 1'b0;
      req1_valid = 1'b0; req1_a = 8'hA5; req1_b = 8'h5A; req1_cin = 1'b1; req1_op = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_carry", rsp_carry, 0);
      chk("rst_op_count", op_count, 0);
      req0_valid = 1'b0;
      rst_n = 1'b1;

      // Directed arithmetic vectors
      run_op(1'b0, 8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0);
      run_op(1'b1, 8'd200, 8'd200, 1'b0, 1'b0, 8'd144, 1'b1);
      run_op(1'b0, 8'd10,  8'd10,  1'b1, 1'b1, 8'd0,   1'b1);
      run_op(1'b0, 8'd1,   8'd2,   1'b1, 1'b1, 8'd255, 1'b0);
      run_op(1'b1, 8'd15,  8'd31,  1'b1, 1'b1, 8'd240, 1'b0);
      run_op(1'b0, 8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1);

      // Fairness from reset: both requesters hold valid for six operations
      do_reset();
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_cin = 1'b0; req0_op = 1'b0;
      req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4; req1_cin = 1'b0; req1_op = 1'b0;
      got = 0;
      for (int c = 0; c < 60 && got < 6; c++) begin
         @(negedge clk);
         chk("one_ready", {31'd0, req0_ready && req1_ready}, 0);
         if (rsp_valid && rsp_ready) begin
            ids[got] = rsp_id;
            chk("fair_sum", rsp_sum, rsp_id ? 8'd7 : 8'd2);
            got++;
         end
      end
      chk("fair_count", got, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("fair_id%0d", i), ids[i], i % 2);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      exp_cnt += 6;
      @(negedge clk);
      chk("fair_op_count_wrap", op_count, cnt_mod(exp_cnt));
      chk("fair_idle", busy, 0);

      // Backpressure: hold the response for five cycles
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6; req0_cin = 1'b0; req0_op = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0; req0_a = 8'd99;
      req1_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_sum", rsp_sum, 8'd11);
         chk("bp_carry", rsp_carry, 0);
         chk("bp_id", rsp_id, 0);
         chk("bp_busy", busy, 1);
         chk("bp_readies", {req0_ready, req1_ready}, 0);
         chk("bp_op_count", op_count, cnt_mod(exp_cnt));
      end
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      chk("bp_done_valid", rsp_valid, 0);
      chk("bp_done_busy", busy, 0);
      chk("bp_done_count", op_count, cnt_mod(exp_cnt));

      // Reset in EXEC: requester 0 served last, so only reset restores its tie win
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 8'd50; req0_b = 8'd60; req0_cin = 1'b0; req0_op = 1'b0;
      @(posedge clk); #2;
      req0_valid = 1'b0;
      chk("pre_rst_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_count", op_count, 0);
      chk("mid_rst_sum", rsp_sum, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req1_a = 8'd9; req1_b = 8'd9; req1_cin = 1'b0; req1_op = 1'b0;
      #1;
      chk("mid_rst_readies", {req0_ready, req1_ready}, 0);
      @(posedge clk);
      @(negedge clk);
      chk("held_rst_valid", rsp_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("tie_after_rst", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 1);
      chk("post_rst_id", rsp_id, 0);
      chk("post_rst_sum", rsp_sum, 8'd110);
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_count", op_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
